gsim_sched: RTL and testbench
=============================

GSIM_SCHED -- requirements
Module: gsim_sched

Interface
REQ-001 Parameter N_ITER, default 64, is the number of Gauss-Seidel sweeps over the 16-element vector.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_en  input  1  b_in sample valid.
REQ-005 b_in  input  16  signed integer right-hand-side element, index order 0..15.
REQ-006 cu_b  output  32  b operand to Computation_Unit.
REQ-007 cu_x0..cu_x5  output  32 each  neighbour operands (x[i-1], x[i+1], x[i-2], x[i+2], x[i-3], x[i+3]).
REQ-008 cu_x_new  input  32  Computation_Unit result, valid one cycle after operands are driven.
REQ-009 out_valid  output  1  x_out valid.
REQ-010 x_out  output  32  solution element, signed Q16.16, index order 0..15.

Function
REQ-011 The block SHALL implement states IDLE, LOAD, ITER, DRAIN and OUT.
REQ-012 In IDLE/LOAD, each in_en cycle SHALL store {b_in,16'h0} into b[k], with k = 0..15; gaps in in_en are allowed.
REQ-013 The cycle after the 16th accepted sample, the state SHALL be ITER with idx=0 and sweep=0.
REQ-014 in_en SHALL be ignored in ITER, DRAIN and OUT.
REQ-015 In ITER, each cycle SHALL issue index idx: cu_b=b[idx], with the neighbour operands per REQ-007.
REQ-016 Neighbours outside 0..15 SHALL be driven as 0.
REQ-017 For idx>0, cu_x0 SHALL be cu_x_new, combinationally forwarded from the previous cycle's issue; for idx=0, cu_x0 SHALL be 0.
REQ-018 Each ITER/DRAIN cycle following an issue of index j SHALL write cu_x_new into x[j].
REQ-019 Issue SHALL be continuous with no bubble: idx wraps 15→0 and increments sweep.
REQ-020 Issuing index 0 while x[15] is being written is legal, because index 0 does not read x[15].
REQ-021 After index 15 of sweep N_ITER-1, the block SHALL spend one DRAIN cycle (writeback of x[15], operands 0) and then enter OUT.
REQ-022 OUT SHALL last exactly 16 cycles, with out_valid=1 and x_out=x[k] for k=0..15.
REQ-023 After OUT the block SHALL return to IDLE, clearing the x array, b array and counters.
REQ-024 Latency: with the 16th in_en in cycle c, out_valid SHALL be high in cycles c+16*N_ITER+2 through c+16*N_ITER+17.
REQ-025 Outside OUT, out_valid=0 and x_out=0.
REQ-026 Outside ITER, all cu_* outputs SHALL be 0.
REQ-027 All arithmetic is 32-bit two's complement; the block itself performs no arithmetic beyond counters.

Reset
REQ-028 Reset SHALL force state IDLE and clear k, idx and sweep, the x and b arrays, out_valid and x_out; it SHALL also drive all cu_* outputs to 0.
REQ-029 Reset asserted in any state mid-operation SHALL abandon the computation, and no out_valid SHALL follow.
REQ-030 A new load SHALL restart at k=0.

Structure
REQ-031 The shared package SHALL hold the state enum, vector length 16, the Q16.16 fraction width 16, and the N_ITER default.
REQ-032 The block SHALL contain no sub-module.
REQ-033 The block SHALL be instantiated beside Computation_Unit inside GSIM, which wires GSIM ports in_en, b_in, out_valid and x_out straight through.

Verification
REQ-034 Bench SHALL pair the block with Computation_Unit and a real-valued reference model; each x_out must be within 8 LSB of the model.
REQ-035 All b=0, N_ITER=64 -> 16 out_valid cycles at c+1026..c+1041, each with x_out=0.
REQ-036 b[0]=20, rest 0, N_ITER=1 -> x_out[0]≈0x00010000 and x_out[1]≈0x0000A666 (±8 LSB), proving forwarding; a broken forward yields x_out[1]=0.
REQ-037 16 samples with random in_en gaps, followed by in_en pulses during ITER -> results identical to the gapless run, and the extra samples are ignored.
REQ-038 Reset asserted at sweep 3, idx 7 -> out_valid stays 0; a fresh 16-sample load then gives correct results with no stale x contamination.
REQ-039 Two back-to-back problems -> the second result is independent of the first (x array cleared on return to IDLE).

Source files
------------

// File: rtl/gsim_sched_pkg.sv
// -----------------------------------------------------------------------------
// gsim_sched_pkg
// Shared definitions for the Gauss-Seidel scheduler:
//   - scheduler state encoding
//   - vector length (16), Q16.16 fraction width (16), default sweep count (64)
//   - vec_t storage type and a bounds-safe element picker used when building
//     neighbour operands (indices outside 0..15 read as zero).
// -----------------------------------------------------------------------------
package gsim_sched_pkg;

  localparam int VEC_LEN        = 16;
  localparam int IDX_W          = $clog2(VEC_LEN);
  localparam int FRAC_W         = 16;
  localparam int WORD_W         = 32;
  localparam int N_ITER_DEFAULT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DRAIN,
    S_OUT
  } state_t;

  typedef logic [WORD_W-1:0] vec_t [VEC_LEN];

  // Element pos of vec, or zero when pos falls off either end of the vector.
  function automatic logic [WORD_W-1:0] pick(input vec_t vec, input int pos);
    logic [WORD_W-1:0] val;
    val = '0;
    if (pos >= 0 && pos < VEC_LEN) val = vec[pos[IDX_W-1:0]];
    return val;
  endfunction

endpackage

// File: rtl/gsim_sched.sv
// -----------------------------------------------------------------------------
// gsim_sched
// Operand scheduler for a 16-element Gauss-Seidel solver. It collects the
// right-hand side b, then streams one index per cycle to an external
// Computation_Unit for N_ITER sweeps, writes each result back into x, and
// finally streams x out.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_en      b_in sample valid (honoured only while idle/loading)
//   b_in       signed integer b element, index order 0..15
//   cu_b       b[idx] in Q16.16 to the Computation_Unit
//   cu_x0..5   neighbours x[i-1], x[i+1], x[i-2], x[i+2], x[i-3], x[i+3]
//   cu_x_new   Computation_Unit result, valid one cycle after its operands
//   out_valid  x_out valid (16 consecutive cycles per problem)
//   x_out      solution element, signed Q16.16, index order 0..15
// -----------------------------------------------------------------------------
module gsim_sched
  import gsim_sched_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_en,
  input  logic [15:0]         b_in,
  output logic [WORD_W-1:0]   cu_b,
  output logic [WORD_W-1:0]   cu_x0,
  output logic [WORD_W-1:0]   cu_x1,
  output logic [WORD_W-1:0]   cu_x2,
  output logic [WORD_W-1:0]   cu_x3,
  output logic [WORD_W-1:0]   cu_x4,
  output logic [WORD_W-1:0]   cu_x5,
  input  logic [WORD_W-1:0]   cu_x_new,
  output logic                out_valid,
  output logic [WORD_W-1:0]   x_out
);

  localparam int                 SWEEP_W    = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(N_ITER - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(VEC_LEN - 1);

  state_t             state;
  logic [IDX_W-1:0]   k;        // load position, later the output position
  logic [IDX_W-1:0]   idx;      // index being issued this cycle
  logic [SWEEP_W-1:0] sweep;
  logic               wb_valid; // an issue happened last cycle
  logic [IDX_W-1:0]   wb_idx;   // index whose result arrives this cycle
  vec_t               b;
  vec_t               x;

  // ---------------------------------------------------------------------------
  // Sequential control, storage and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so that all reads in
  // this block see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      idx       <= '0;
      sweep     <= '0;
      wb_valid  <= 1'b0;
      wb_idx    <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      // NOTE: b and x are flop arrays that are deliberately reset: an abandoned
      // problem must leave no stale x behind for the next load to iterate from.
      for (int i = 0; i < VEC_LEN; i++) begin
        b[i] <= '0;
        x[i] <= '0;
      end
    end else begin
      // Result of last cycle's issue is on cu_x_new now; commit it.
      wb_valid <= (state == S_ITER);
      wb_idx   <= idx;
      if (wb_valid) x[wb_idx] <= cu_x_new;

      case (state)
        S_IDLE, S_LOAD: begin
          if (in_en) begin
            b[k] <= {b_in, {FRAC_W{1'b0}}};
            if (k == LAST_IDX) begin
              state <= S_ITER;
              k     <= '0;
              idx   <= '0;
              sweep <= '0;
            end else begin
              state <= S_LOAD;
              k     <= k + 1'b1;
            end
          end
        end

        S_ITER: begin
          // Back-to-back issue: index 0 of the next sweep may go out while
          // x[15] is being written, since index 0 never reads x[15].
          if (idx == LAST_IDX) begin
            idx <= '0;
            if (sweep == LAST_SWEEP) state <= S_DRAIN;
            else                     sweep <= sweep + 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_DRAIN: begin
          // x[15] lands this edge; x[0] has been stable for a full sweep.
          state     <= S_OUT;
          k         <= '0;
          out_valid <= 1'b1;
          x_out     <= x[0];
        end

        S_OUT: begin
          if (k == LAST_IDX) begin
            state     <= S_IDLE;
            k         <= '0;
            idx       <= '0;
            sweep     <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
            for (int i = 0; i < VEC_LEN; i++) begin
              b[i] <= '0;
              x[i] <= '0;
            end
          end else begin
            k     <= k + 1'b1;
            x_out <= x[k + 1'b1];
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand issue
  // x[i-1] is the result of the previous cycle's issue and is not in x yet, so
  // it is forwarded straight from cu_x_new. x[i-2] and x[i-3] were committed on
  // earlier edges; x[i+1..i+3] still hold the previous sweep's values.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the conditional so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cu_b  = '0;
    cu_x0 = '0;
    cu_x1 = '0;
    cu_x2 = '0;
    cu_x3 = '0;
    cu_x4 = '0;
    cu_x5 = '0;
    if (state == S_ITER) begin
      cu_b  = b[idx];
      cu_x0 = (idx == '0) ? '0 : cu_x_new;
      cu_x1 = pick(x, int'(idx) + 1);
      cu_x2 = pick(x, int'(idx) - 2);
      cu_x3 = pick(x, int'(idx) + 2);
      cu_x4 = pick(x, int'(idx) - 3);
      cu_x5 = pick(x, int'(idx) + 3);
    end
  end

endmodule

// File: tb/tb_gsim_sched.sv
// -----------------------------------------------------------------------------
// tb_gsim_sched
// Two schedulers (N_ITER=64 and N_ITER=1), each paired with a behavioural
// Computation_Unit computing
//   x_new = round((b + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])) / 20)
// in Q16.16. A real-valued Gauss-Seidel model gives the expected solution; a
// per-cycle compare process checks out_valid timing, x_out (within 8 LSB),
// idle-zero outputs and the issued b / forwarded x[i-1] operands.
// -----------------------------------------------------------------------------
module tb_gsim_sched;

  localparam real TOL_LSB = 8.0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- DUT signals: index 0 = N_ITER 64, index 1 = N_ITER 1 ----
  logic        in_en_a, in_en_b;
  logic [15:0] b_in_a, b_in_b;
  logic [31:0] op_a [7];
  logic [31:0] op_b [7];
  logic [31:0] cun_a, cun_b;
  logic        ov_a, ov_b;
  logic [31:0] xo_a, xo_b;

  gsim_sched #(.N_ITER(64)) dut_a (
    .clk(clk), .reset(reset), .in_en(in_en_a), .b_in(b_in_a),
    .cu_b(op_a[0]), .cu_x0(op_a[1]), .cu_x1(op_a[2]), .cu_x2(op_a[3]),
    .cu_x3(op_a[4]), .cu_x4(op_a[5]), .cu_x5(op_a[6]),
    .cu_x_new(cun_a), .out_valid(ov_a), .x_out(xo_a)
  );

  gsim_sched #(.N_ITER(1)) dut_b (
    .clk(clk), .reset(reset), .in_en(in_en_b), .b_in(b_in_b),
    .cu_b(op_b[0]), .cu_x0(op_b[1]), .cu_x1(op_b[2]), .cu_x2(op_b[3]),
    .cu_x3(op_b[4]), .cu_x4(op_b[5]), .cu_x5(op_b[6]),
    .cu_x_new(cun_b), .out_valid(ov_b), .x_out(xo_b)
  );

  // ---- Computation_Unit behaviour (round to nearest) ----
  function automatic logic [31:0] cu_calc(input logic [31:0] o [7]);
    longint s, q;
    s = longint'($signed(o[0]))
      + 13 * (longint'($signed(o[1])) + longint'($signed(o[2])))
      -  6 * (longint'($signed(o[3])) + longint'($signed(o[4])))
      +      (longint'($signed(o[5])) + longint'($signed(o[6])));
    if (s >= 0) q = (s + 10) / 20;
    else        q = -((-s + 10) / 20);
    return q[31:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cun_a <= '0;
      cun_b <= '0;
    end else begin
      cun_a <= cu_calc(op_a);
      cun_b <= cu_calc(op_b);
    end
  end

  // ---- Real-valued Gauss-Seidel reference ----
  function automatic real xv(input real a [16], input int j);
    if (j < 0 || j > 15) return 0.0;
    return a[j];
  endfunction

  function automatic void gs_model(input int bb [16], input int n, output real xr [16]);
    real s;
    for (int i = 0; i < 16; i++) xr[i] = 0.0;
    for (int sw = 0; sw < n; sw++) begin
      for (int i = 0; i < 16; i++) begin
        s = real'(bb[i])
          + 13.0 * (xv(xr, i - 1) + xv(xr, i + 1))
          -  6.0 * (xv(xr, i - 2) + xv(xr, i + 2))
          +        (xv(xr, i - 3) + xv(xr, i + 3));
        xr[i] = s / 20.0;
      end
    end
  endfunction

  // ---- Scoreboard state ----
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_it [2] = '{64, 1};
  int  c_done [2];
  bit  armed [2] = '{1'b0, 1'b0};
  int  bv [2][16];
  real exp_x [2][16];
  logic [31:0] x_cap [2][16];
  int  n_valid [2] = '{0, 0};

  task automatic check_eq(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic check_near(input string name, input real got, input real want, input real tol);
    real d;
    n_checks++;
    d = got - want;
    if (d < 0.0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0f expected %0f (tol %0f)", name, got, want, tol);
  endtask

  // Per-cycle comparison of one instance against the model.
  task automatic compare_inst(input int inst, input logic ov, input logic [31:0] xo,
                              input logic [31:0] ops [7], input logic [31:0] cun);
    int t0, o0, k;
    bit in_iter, in_out;
    logic [15:0] bl;
    if (reset) begin
      check_eq($sformatf("dut%0d out_valid during reset @%0d", inst, cyc), longint'(ov), 0);
      armed[inst] = 1'b0;
      return;
    end
    in_iter = 1'b0;
    in_out  = 1'b0;
    t0 = 0;
    o0 = 0;
    if (armed[inst]) begin
      t0 = c_done[inst] + 1;
      o0 = c_done[inst] + 16 * n_it[inst] + 2;
      in_iter = (cyc >= t0) && (cyc <= o0 - 2);
      in_out  = (cyc >= o0) && (cyc <= o0 + 15);
      if (cyc >= o0 + 15) armed[inst] = 1'b0;
    end
    if (ov) n_valid[inst]++;
    check_eq($sformatf("dut%0d out_valid @%0d", inst, cyc), longint'(ov), longint'(in_out));
    if (in_out) begin
      k = cyc - o0;
      x_cap[inst][k] = xo;
      check_near($sformatf("dut%0d x_out[%0d] @%0d", inst, k, cyc),
                 real'($signed(xo)), exp_x[inst][k] * 65536.0, TOL_LSB);
    end else begin
      check_eq($sformatf("dut%0d x_out idle @%0d", inst, cyc), longint'(xo), 0);
    end
    if (in_iter) begin
      k  = (cyc - t0) % 16;
      bl = bv[inst][k][15:0];
      check_eq($sformatf("dut%0d cu_b idx %0d @%0d", inst, k, cyc),
               longint'(ops[0]), longint'({bl, 16'h0000}));
      if (k == 0)
        check_eq($sformatf("dut%0d cu_x0 at idx 0 @%0d", inst, cyc), longint'(ops[1]), 0);
      else
        check_eq($sformatf("dut%0d cu_x0 forward @%0d", inst, cyc), longint'(ops[1]), longint'(cun));
    end else begin
      check_eq($sformatf("dut%0d cu_* idle @%0d", inst, cyc),
               longint'(ops[0] | ops[1] | ops[2] | ops[3] | ops[4] | ops[5] | ops[6]), 0);
    end
  endtask

  always @(negedge clk) begin
    compare_inst(0, ov_a, xo_a, op_a, cun_a);
    compare_inst(1, ov_b, xo_b, op_b, cun_b);
  end

  // ---- Stimulus helpers (called at #1 after a rising edge) ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic en, input logic [15:0] v);
    if (inst == 0) begin in_en_a = en; b_in_a = v; end
    else           begin in_en_b = en; b_in_b = v; end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Loads 16 samples; first sample is driven in the current cycle.
  task automatic load(input int inst, input int vals [16], input bit gaps);
    real xr [16];
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        for (int g = 0; g < (i * 7) % 4; g++) begin
          drive(inst, 1'b0, 16'hDEAD);
          step();
        end
      end
      drive(inst, 1'b1, vals[i][15:0]);
      if (i == 15) begin
        for (int j = 0; j < 16; j++) bv[inst][j] = vals[j];
        gs_model(vals, n_it[inst], xr);
        for (int j = 0; j < 16; j++) exp_x[inst][j] = xr[j];
        c_done[inst] = cyc;
        armed[inst]  = 1'b1;
      end
      step();
    end
    drive(inst, 1'b0, 16'h0000);
  endtask

  // Single in_en pulse carrying a junk sample.
  task automatic junk_pulse(input int inst);
    drive(inst, 1'b1, 16'h7FFF);
    step();
    drive(inst, 1'b0, 16'h0000);
  endtask

  int p_zero [16];
  int p_a    [16];
  int p_b    [16];
  int p_imp  [16];
  real pin [16];
  int  c;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    p_zero = '{default: 0};
    p_a    = '{5, -3, 12, 0, 7, -9, 4, 1, -6, 10, 2, -1, 8, -4, 3, 6};
    p_b    = '{-10, 4, 0, 15, -7, 2, 9, -3, 11, -5, 0, 6, -8, 1, 13, -2};
    p_imp  = '{20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    reset   = 1'b1;
    in_en_a = 1'b0; b_in_a = '0;
    in_en_b = 1'b0; b_in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    check_eq("reset out_valid", longint'(ov_a), 0);
    check_eq("reset x_out", longint'(xo_a), 0);
    check_eq("reset cu_b", longint'(op_a[0]), 0);

    // Model pins: hand-computed impulse response of one sweep.
    gs_model(p_imp, 1, pin);
    check_near("model impulse x0", pin[0] * 65536.0, 65536.0, 0.01);
    check_near("model impulse x1", pin[1] * 65536.0, 42598.4, 0.01);
    check_near("model impulse x2", pin[2] * 65536.0, 8028.16, 0.01);

    // N_ITER=1 impulse: proves x[i-1] forwarding.
    load(1, p_imp, 1'b0);
    wait_until(c_done[1] + 16 + 20);
    check_near("impulse x_out[0]", real'($signed(x_cap[1][0])), 65536.0, TOL_LSB);
    check_near("impulse x_out[1]", real'($signed(x_cap[1][1])), real'(32'h0000A666), TOL_LSB);
    check_near("impulse x_out[2]", real'($signed(x_cap[1][2])), 8028.0, TOL_LSB);

    // All-zero b, then two back-to-back problems loaded the cycle OUT ends.
    load(0, p_zero, 1'b0);
    c = c_done[0];
    wait_until(c + 1026);
    check_eq("zero run first out_valid at c+1026", longint'(ov_a), 1);
    wait_until(c + 16 * 64 + 18);
    load(0, p_a, 1'b0);
    wait_until(c_done[0] + 16 * 64 + 18);
    load(0, p_b, 1'b0);
    wait_until(c_done[0] + 16 * 64 + 18);

    // Gapped load of p_a with ignored in_en pulses during ITER.
    load(0, p_a, 1'b1);
    c = c_done[0];
    wait_until(c + 5);
    junk_pulse(0);
    wait_until(c + 300);
    junk_pulse(0);
    wait_until(c + 1000);
    junk_pulse(0);
    wait_until(c + 16 * 64 + 18);

    // Reset at sweep 3, idx 7, then a fresh load.
    load(0, p_b, 1'b0);
    c = c_done[0];
    wait_until(c + 56);
    reset = 1'b1;
    step();
    reset = 1'b0;
    load(0, p_a, 1'b0);
    wait_until(c_done[0] + 16 * 64 + 20);

    // Five completed problems on the 64-sweep instance, one on the other.
    check_eq("dut0 total out_valid cycles", longint'(n_valid[0]), 80);
    check_eq("dut1 total out_valid cycles", longint'(n_valid[1]), 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
